// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-fetch-address selection with stall freeze,
// a one-entry pending-redirect buffer and misaligned register-jump trapping.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
   parameter int          OFF_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        int_req,
   input  logic        eret,
   input  logic [29:0] epc,
   input  logic        jump,
   input  logic        jr,
   input  logic        branch,
   input  logic        cmp,
   input  logic [29:0] br_base,
   input  logic [25:0] imm,
   input  logic [31:0] jr_addr,
   output logic [29:0] pc,
   output logic        pend_valid,
   output logic        exc_adel,
   output logic [31:0] bad_vaddr
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   localparam int         SH   = 30 - OFF_W;

   logic [0:0]  state;
   logic [29:0] buf_pc;
   logic        buf_trap;
   logic [31:0] buf_bad;

   logic        redir;
   logic        redir_trap;
   logic [29:0] redir_pc;
   logic [29:0] imm30;
   logic [29:0] br_off;

   // Sign-extend the low OFF_W bits of imm by shifting them to the top and back.
   assign imm30  = {{4{imm[25]}}, imm};
   assign br_off = $signed(imm30 << SH) >>> SH;

   always_comb begin
      redir      = 1'b1;
      redir_trap = 1'b0;
      redir_pc   = pc + 30'd1;
      if (eret) begin
         redir_pc = epc;
      end else if (jump) begin
         redir_pc = {br_base[29:26], imm};
      end else if (jr) begin
         if (jr_addr[1:0] == 2'b00) begin
            redir_pc = jr_addr[31:2];
         end else begin
            redir_pc   = EXC_VEC[31:2];
            redir_trap = 1'b1;
         end
      end else if (branch && cmp) begin
         redir_pc = br_base + br_off;
      end else begin
         redir = 1'b0;
      end
   end

   assign pend_valid = (state == HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC[31:2];
         state     <= RUN;
         buf_pc    <= '0;
         buf_trap  <= 1'b0;
         buf_bad   <= '0;
         exc_adel  <= 1'b0;
         bad_vaddr <= '0;
      end else begin
         exc_adel <= 1'b0;
         if (int_req) begin
            pc       <= EXC_VEC[31:2];
            state    <= RUN;
            buf_trap <= 1'b0;
         end else if (stall) begin
            // Fetch is frozen: capture any redirect so it survives the stall.
            if (redir) begin
               buf_pc   <= redir_pc;
               buf_trap <= redir_trap;
               buf_bad  <= jr_addr;
               state    <= HOLD;
            end
         end else if (state == HOLD) begin
            // Decode now holds the delay slot, so its redirect is ignored.
            pc    <= buf_pc;
            state <= RUN;
            if (buf_trap) begin
               exc_adel  <= 1'b1;
               bad_vaddr <= buf_bad;
            end
            buf_trap <= 1'b0;
         end else begin
            pc <= redir_pc;
            if (redir_trap) begin
               exc_adel  <= 1'b1;
               bad_vaddr <= jr_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a behavioural next-PC model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, int_req, eret, jump, jr, branch, cmp;
   logic [29:0] epc, br_base;
   logic [25:0] imm;
   logic [31:0] jr_addr;
   logic [29:0] pc;
   logic        pend_valid, exc_adel;
   logic [31:0] bad_vaddr;

   int checks = 0;
   int errors = 0;

   localparam logic [29:0] RST_W = 30'h0000_3000 >> 2;
   localparam logic [29:0] EXC_W = 30'h0000_4180 >> 2;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .int_req(int_req), .eret(eret),
      .epc(epc), .jump(jump), .jr(jr), .branch(branch), .cmp(cmp),
      .br_base(br_base), .imm(imm), .jr_addr(jr_addr), .pc(pc),
      .pend_valid(pend_valid), .exc_adel(exc_adel), .bad_vaddr(bad_vaddr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; int_req = 0; eret = 0; jump = 0; jr = 0; branch = 0; cmp = 0;
      epc = '0; br_base = '0; imm = '0; jr_addr = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pc, pend_valid, exc_adel, bad_vaddr} !== {RST_W, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state: pc=%h pend=%b adel=%b bva=%h exp pc=%h", {pc, 2'b00}, pend_valid, exc_adel, bad_vaddr, {RST_W, 2'b00});
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if ({pc, pend_valid, exc_adel} !== {RST_W + 30'(i), 2'b00}) begin
            errors++;
            $display("FAIL reset_seq%0d: pc=%h pend=%b adel=%b exp pc=%h", i, {pc, 2'b00}, pend_valid, exc_adel, {RST_W + 30'(i), 2'b00});
         end
      end
   endtask

   task automatic test_branch();
      logic [29:0] p;
      idle();
      branch = 1; cmp = 1; br_base = 30'h0000_3010 >> 2; imm = 26'h000_FFFC;
      tick();
      checks++;
      if (pc !== 30'h0000_3000 >> 2) begin
         errors++;
         $display("FAIL branch_taken: pc=%h exp 00003000", {pc, 2'b00});
      end
      p = pc;
      cmp = 0;
      tick();
      checks++;
      if (pc !== p + 30'd1) begin
         errors++;
         $display("FAIL branch_not_taken: pc=%h exp %h", {pc, 2'b00}, {p + 30'd1, 2'b00});
      end
      idle();
   endtask

   task automatic test_stall_jump();
      logic [29:0] p;
      idle();
      p = pc;
      stall = 1; jump = 1; imm = 26'h000_0C40; br_base = 30'h0000_0C05;
      for (int i = 0; i < 3; i++) begin
         tick();
         jump = 0;
         checks++;
         if ({pc, pend_valid} !== {p, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold%0d: pc=%h pend=%b exp pc=%h pend=1", i, {pc, 2'b00}, pend_valid, {p, 2'b00});
         end
      end
      stall = 0;
      tick();
      checks++;
      if ({pc, pend_valid} !== {30'h0000_3100 >> 2, 1'b0}) begin
         errors++;
         $display("FAIL stall_release: pc=%h pend=%b exp pc=00003100 pend=0", {pc, 2'b00}, pend_valid);
      end
   endtask

   task automatic test_jr_trap();
      idle();
      jr = 1; jr_addr = 32'h0000_3006;
      tick();
      checks++;
      if ({pc, exc_adel, bad_vaddr} !== {EXC_W, 1'b1, 32'h0000_3006}) begin
         errors++;
         $display("FAIL jr_trap: pc=%h adel=%b bva=%h exp pc=00004180 adel=1 bva=00003006", {pc, 2'b00}, exc_adel, bad_vaddr);
      end
      idle();
      tick();
      checks++;
      if ({exc_adel, bad_vaddr} !== {1'b0, 32'h0000_3006}) begin
         errors++;
         $display("FAIL jr_trap_pulse: adel=%b bva=%h exp adel=0 bva=00003006", exc_adel, bad_vaddr);
      end
      jr = 1; jr_addr = 32'h0000_3008;
      tick();
      checks++;
      if ({pc, exc_adel} !== {30'h0000_3008 >> 2, 1'b0}) begin
         errors++;
         $display("FAIL jr_aligned: pc=%h adel=%b exp pc=00003008 adel=0", {pc, 2'b00}, exc_adel);
      end
      jump = 1; imm = 26'h000_0D00; jr_addr = 32'h0000_3001;
      tick();
      checks++;
      if ({pc, exc_adel} !== {30'h0000_0D00, 1'b0}) begin
         errors++;
         $display("FAIL jump_over_jr: pc=%h adel=%b exp pc=00003400 adel=0", {pc, 2'b00}, exc_adel);
      end
      idle();
   endtask

   task automatic test_int();
      idle();
      stall = 1; jump = 1; imm = 26'h000_0C40;
      tick();
      jump = 0; int_req = 1;
      tick();
      checks++;
      if ({pc, pend_valid} !== {EXC_W, 1'b0}) begin
         errors++;
         $display("FAIL int_in_hold: pc=%h pend=%b exp pc=00004180 pend=0", {pc, 2'b00}, pend_valid);
      end
      idle();
      tick();
      int_req = 1; eret = 1; epc = 30'h0000_0C00;
      tick();
      checks++;
      if (pc !== EXC_W) begin
         errors++;
         $display("FAIL int_over_eret: pc=%h exp 00004180", {pc, 2'b00});
      end
      idle();
   endtask

   task automatic test_wrap();
      idle();
      jump = 1; br_base = 30'h3C00_0000; imm = 26'h3FF_FFFF;
      tick();
      checks++;
      if (pc !== 30'h3FFF_FFFF) begin
         errors++;
         $display("FAIL wrap_setup: pc=%h exp fffffffc", {pc, 2'b00});
      end
      idle();
      tick();
      checks++;
      if (pc !== 30'h0) begin
         errors++;
         $display("FAIL wrap: pc=%h exp 00000000", {pc, 2'b00});
      end
   endtask

   task automatic test_reset_hold();
      idle();
      stall = 1; eret = 1; epc = 30'h0000_1234;
      tick();
      reset = 1;
      #1;
      checks++;
      if ({pc, pend_valid} !== {RST_W, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_hold: pc=%h pend=%b exp pc=00003000 pend=0", {pc, 2'b00}, pend_valid);
      end
      idle();
      tick();
      reset = 0;
      tick();
      checks++;
      if ({pc, pend_valid} !== {RST_W + 30'd1, 1'b0}) begin
         errors++;
         $display("FAIL reset_release_fetch: pc=%h pend=%b exp pc=00003004 pend=0", {pc, 2'b00}, pend_valid);
      end
   endtask

   task automatic test_random();
      logic [29:0] m_pc, m_buf, tgt;
      logic        m_pend, m_btrap, m_adel, trap, has;
      logic [31:0] m_bbad, m_bva;
      int          off;
      do_reset();
      m_pc = RST_W; m_pend = 0; m_buf = '0; m_btrap = 0; m_bbad = '0; m_adel = 0; m_bva = '0;
      for (int c = 0; c < 600; c++) begin
         stall   = ($urandom_range(0, 99) < 35);
         int_req = ($urandom_range(0, 99) < 5);
         eret    = ($urandom_range(0, 99) < 10);
         jump    = ($urandom_range(0, 99) < 15);
         jr      = ($urandom_range(0, 99) < 20);
         branch  = ($urandom_range(0, 99) < 25);
         cmp     = $urandom_range(0, 1);
         epc     = 30'($urandom);
         br_base = 30'($urandom);
         imm     = 26'($urandom);
         jr_addr = $urandom;
         // Reference redirect from the priority list, in byte/word arithmetic.
         has = 1; trap = 0; tgt = m_pc + 30'd1;
         if (eret) tgt = epc;
         else if (jump) tgt = {br_base[29:26], imm};
         else if (jr && (jr_addr % 4 == 0)) tgt = 30'(jr_addr / 4);
         else if (jr) begin tgt = EXC_W; trap = 1; end
         else if (branch && cmp) begin
            off = int'($signed(imm[15:0]));
            tgt = 30'(int'(br_base) + off);
         end else has = 0;
         m_adel = 0;
         if (int_req) begin
            m_pc = EXC_W; m_pend = 0;
         end else if (stall) begin
            if (has) begin m_pend = 1; m_buf = tgt; m_btrap = trap; m_bbad = jr_addr; end
         end else if (m_pend) begin
            m_pc = m_buf; m_pend = 0;
            if (m_btrap) begin m_adel = 1; m_bva = m_bbad; end
         end else begin
            m_pc = tgt;
            if (trap) begin m_adel = 1; m_bva = jr_addr; end
         end
         tick();
         checks++;
         if ({pc, pend_valid, exc_adel, bad_vaddr} !== {m_pc, m_pend, m_adel, m_bva}) begin
            errors++;
            $display("FAIL random_c%0d: pc=%h pend=%b adel=%b bva=%h exp pc=%h pend=%b adel=%b bva=%h",
                     c, {pc, 2'b00}, pend_valid, exc_adel, bad_vaddr, {m_pc, 2'b00}, m_pend, m_adel, m_bva);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      test_reset();
      test_branch();
      test_stall_jump();
      test_jr_trap();
      test_int();
      test_wrap();
      test_reset_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
